// File: rtl/set_assoc_cache_ctrl.sv
// rtl/set_assoc_cache_ctrl.sv - set-associative cache tag/state controller with true-LRU ages
module set_assoc_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int INDEX_W    = 14,
    parameter int WAYS       = 4,
    parameter int WRITE_BACK = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   n,
    input  logic [ADDR_W-1:0]            add_in,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_write,
    output logic [ADDR_W-OFFSET_W-1:0]   add_out,
    output logic                         resp_valid,
    output logic                         resp_hit,
    output logic [31:0]                  hit,
    output logic [31:0]                  miss,
    output logic [31:0]                  reads,
    output logic [31:0]                  writes,
    output logic [31:0]                  evicts
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam int LA_W  = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

    state_t state, state_d;

    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [AGE_W-1:0] age_mem   [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];
    logic [WAYS-1:0]  dirty_mem [SETS];

    logic [INDEX_W-1:0] init_idx;
    logic [3:0]         cmd_n_q;
    logic [LA_W-1:0]    cmd_line_q;
    logic               hit_q;
    logic [AGE_W-1:0]   victim_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               is_rd, is_wr, is_inv, is_rdwr;
    logic               lookup_hit, inv_found;
    logic [AGE_W-1:0]   hit_way, inv_way, lru_way, victim;
    logic               touch;
    logic [AGE_W-1:0]   touch_way;
    logic [LA_W-1:0]    wb_addr;

    assign idx     = cmd_line_q[INDEX_W-1:0];
    assign tag     = cmd_line_q[LA_W-1:INDEX_W];
    assign is_rd   = (cmd_n_q == 4'd0);
    assign is_wr   = (cmd_n_q == 4'd1);
    assign is_inv  = (cmd_n_q == 4'd3);
    assign is_rdwr = is_rd || is_wr;

    assign cmd_ready     = (state == S_IDLE);
    assign mem_req_valid = (state == S_WB) || (state == S_FILL);
    assign mem_req_write = (state == S_WB);
    assign resp_valid    = (state == S_RESP);

    // Victim: lowest invalid way first, otherwise the way holding the oldest age.
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
                lookup_hit = 1'b1;
                hit_way    = AGE_W'(w);
            end
            if (!valid_mem[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_mem[idx][w] == AGE_W'(WAYS - 1))
                lru_way = AGE_W'(w);
        end
        victim  = inv_found ? inv_way : lru_way;
        wb_addr = lookup_hit ? cmd_line_q : {tag_mem[idx][victim], idx};
    end

    always_comb begin
        state_d = state;
        case (state)
            S_INIT:   if (&init_idx) state_d = S_IDLE;
            S_IDLE:   if (cmd_valid) state_d = (n == 4'd8) ? S_INIT : S_LOOKUP;
            S_LOOKUP: begin
                if (is_rdwr) begin
                    if (lookup_hit)
                        state_d = (is_wr && WRITE_BACK == 0) ? S_WB : S_RESP;
                    else if (valid_mem[idx][victim] && dirty_mem[idx][victim])
                        state_d = S_WB;
                    else
                        state_d = S_FILL;
                end else if (is_inv && lookup_hit && dirty_mem[idx][hit_way]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WB:     if (mem_req_ready) state_d = (is_rdwr && !hit_q) ? S_FILL : S_RESP;
            S_FILL:   if (mem_req_ready) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            init_idx   <= '0;
            cmd_n_q    <= '0;
            cmd_line_q <= '0;
            hit_q      <= 1'b0;
            victim_q   <= '0;
            add_out    <= '0;
            resp_hit   <= 1'b0;
            hit        <= '0;
            miss       <= '0;
            reads      <= '0;
            writes     <= '0;
            evicts     <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_INIT: init_idx <= init_idx + 1'b1;
                S_IDLE: if (cmd_valid) begin
                    cmd_n_q    <= n;
                    cmd_line_q <= add_in[ADDR_W-1:OFFSET_W];
                    if (n == 4'd0) reads  <= reads + 1'b1;
                    if (n == 4'd1) writes <= writes + 1'b1;
                    if (n == 4'd8) begin
                        init_idx <= '0;
                        hit      <= '0;
                        miss     <= '0;
                        reads    <= '0;
                        writes   <= '0;
                        evicts   <= '0;
                    end
                end
                S_LOOKUP: begin
                    hit_q    <= lookup_hit;
                    victim_q <= victim;
                    resp_hit <= lookup_hit && (is_rdwr || is_inv);
                    if (is_rdwr) begin
                        if (lookup_hit) begin
                            hit <= hit + 1'b1;
                        end else begin
                            miss <= miss + 1'b1;
                            if (valid_mem[idx][victim]) evicts <= evicts + 1'b1;
                        end
                    end
                    if (state_d == S_WB)        add_out <= wb_addr;
                    else if (state_d == S_FILL) add_out <= cmd_line_q;
                end
                S_WB: if (mem_req_ready) add_out <= cmd_line_q;
                default: ;
            endcase
        end
    end

    assign touch     = (state == S_LOOKUP && is_rdwr && lookup_hit) ||
                       (state == S_FILL && mem_req_ready);
    assign touch_way = (state == S_FILL) ? victim_q : hit_way;

    // Array storage is initialised by the INIT walk rather than by reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            valid_mem[init_idx] <= '0;
            dirty_mem[init_idx] <= '0;
            for (int w = 0; w < WAYS; w++)
                age_mem[init_idx][w] <= AGE_W'(w);
        end else begin
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        age_mem[idx][w] <= '0;
                    else if (age_mem[idx][w] < age_mem[idx][touch_way])
                        age_mem[idx][w] <= age_mem[idx][w] + 1'b1;
                end
            end
            if (state == S_LOOKUP && is_inv && lookup_hit) begin
                valid_mem[idx][hit_way] <= 1'b0;
                dirty_mem[idx][hit_way] <= 1'b0;
            end
            if (state == S_LOOKUP && is_wr && lookup_hit && WRITE_BACK != 0)
                dirty_mem[idx][hit_way] <= 1'b1;
            if (state == S_FILL && mem_req_ready) begin
                tag_mem[idx][victim_q]   <= tag;
                valid_mem[idx][victim_q] <= 1'b1;
                dirty_mem[idx][victim_q] <= is_wr && (WRITE_BACK != 0);
            end
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// tb/tb_set_assoc_cache_ctrl.sv - directed bench for set_assoc_cache_ctrl (write-back and write-through)
module tb_set_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [3:0]  n;
    logic [15:0] add_in;
    logic        mem_req_ready;
    logic        sel;

    logic b_cmd_ready, b_mreq_valid, b_mreq_write, b_resp_valid, b_resp_hit;
    logic t_cmd_ready, t_mreq_valid, t_mreq_write, t_resp_valid, t_resp_hit;
    logic [9:0]  b_add_out, t_add_out;
    logic [31:0] b_hit, b_miss, b_reads, b_writes, b_evicts;
    logic [31:0] t_hit, t_miss, t_reads, t_writes, t_evicts;

    int n_checks = 0;
    int n_fail   = 0;
    logic       wq[$];
    logic [9:0] aq[$];

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(.ADDR_W(16), .OFFSET_W(6), .INDEX_W(2), .WAYS(2), .WRITE_BACK(1)) u_wb (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .n(n), .add_in(add_in),
        .mem_req_valid(b_mreq_valid), .mem_req_ready(mem_req_ready), .mem_req_write(b_mreq_write),
        .add_out(b_add_out), .resp_valid(b_resp_valid), .resp_hit(b_resp_hit),
        .hit(b_hit), .miss(b_miss), .reads(b_reads), .writes(b_writes), .evicts(b_evicts));

    set_assoc_cache_ctrl #(.ADDR_W(16), .OFFSET_W(6), .INDEX_W(2), .WAYS(2), .WRITE_BACK(0)) u_wt (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready), .n(n), .add_in(add_in),
        .mem_req_valid(t_mreq_valid), .mem_req_ready(mem_req_ready), .mem_req_write(t_mreq_write),
        .add_out(t_add_out), .resp_valid(t_resp_valid), .resp_hit(t_resp_hit),
        .hit(t_hit), .miss(t_miss), .reads(t_reads), .writes(t_writes), .evicts(t_evicts));

    wire        s_cmd_ready  = sel ? t_cmd_ready  : b_cmd_ready;
    wire        s_mreq_valid = sel ? t_mreq_valid : b_mreq_valid;
    wire        s_mreq_write = sel ? t_mreq_write : b_mreq_write;
    wire        s_resp_valid = sel ? t_resp_valid : b_resp_valid;
    wire        s_resp_hit   = sel ? t_resp_hit   : b_resp_hit;
    wire [9:0]  s_add_out    = sel ? t_add_out    : b_add_out;
    wire [31:0] s_hit        = sel ? t_hit        : b_hit;
    wire [31:0] s_miss       = sel ? t_miss       : b_miss;
    wire [31:0] s_reads      = sel ? t_reads      : b_reads;
    wire [31:0] s_writes     = sel ? t_writes     : b_writes;
    wire [31:0] s_evicts     = sel ? t_evicts     : b_evicts;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] req_at(input int i);
        if (i < aq.size()) return (32'(wq[i]) << 16) | 32'(aq[i]);
        return 32'hdead_beef;
    endfunction

    task automatic check_counts(input string tag, input logic [31:0] eh, em, er, ew, ee);
        check_val({tag, ".hit"},    s_hit,    eh);
        check_val({tag, ".miss"},   s_miss,   em);
        check_val({tag, ".reads"},  s_reads,  er);
        check_val({tag, ".writes"}, s_writes, ew);
        check_val({tag, ".evicts"}, s_evicts, ee);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (s_cmd_ready) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic start_cmd(input logic [3:0] c, input logic [15:0] a);
        int waited = 0;
        while (!s_cmd_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_cmd_ready) check_val("cmd_ready_timeout", 32'(s_cmd_ready), 32'd1);
        n = c;
        add_in = a;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // lat = number of clock edges after the accepting edge until resp_valid is seen.
    task automatic wait_resp(output int lat, output logic rhit);
        lat = -1;
        rhit = 1'b0;
        wq.delete();
        aq.delete();
        for (int i = 1; i <= 200; i++) begin
            if (s_mreq_valid && mem_req_ready) begin
                wq.push_back(s_mreq_write);
                aq.push_back(s_add_out);
            end
            @(posedge clk); #1;
            if (s_resp_valid) begin
                lat = i;
                rhit = s_resp_hit;
                break;
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] c, input logic [15:0] a,
                           input int exp_lat, input logic exp_hit);
        int lat;
        logic rhit;
        start_cmd(c, a);
        wait_resp(lat, rhit);
        check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ".resp_hit"}, 32'(rhit), 32'(exp_hit));
    endtask

    initial begin
        int cnt;
        int stable;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        n = '0;
        add_in = '0;
        mem_req_ready = 1'b1;
        sel = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst.cmd_ready", 32'(b_cmd_ready), 0);
        check_val("rst.mem_req_valid", 32'(b_mreq_valid), 0);
        check_val("rst.mem_req_write", 32'(b_mreq_write), 0);
        check_val("rst.add_out", 32'(b_add_out), 0);
        check_val("rst.resp_valid", 32'(b_resp_valid), 0);
        check_val("rst.resp_hit", 32'(b_resp_hit), 0);
        rst_n = 1'b1;
        wait_ready(cnt);
        check_val("init.cycles", 32'(cnt), 4);
        check_counts("init", 0, 0, 0, 0, 0);

        // Cold miss then hit on the same line.
        run_cmd("rd0_miss", 4'd0, 16'h0000, 2, 1'b0);
        check_val("rd0_miss.nreq", 32'(aq.size()), 1);
        check_val("rd0_miss.req0", req_at(0), 32'h0000_0000);
        run_cmd("rd0_hit", 4'd0, 16'h0000, 1, 1'b1);
        check_counts("after_rd0", 1, 1, 2, 0, 0);

        // Dirty LRU line evicted: write-back of 0x000 then fill of 0x008.
        run_cmd("wr0_hit", 4'd1, 16'h0000, 1, 1'b1);
        run_cmd("rd100_miss", 4'd0, 16'h0100, 2, 1'b0);
        check_val("rd100_miss.req0", req_at(0), 32'h0000_0004);
        run_cmd("rd200_evict", 4'd0, 16'h0200, 3, 1'b0);
        check_val("rd200_evict.nreq", 32'(aq.size()), 2);
        check_val("rd200_evict.req0", req_at(0), 32'h0001_0000);
        check_val("rd200_evict.req1", req_at(1), 32'h0000_0008);
        check_counts("after_evict", 2, 3, 4, 1, 1);

        // Invalidate a dirty line flushes it; the next read misses without eviction.
        run_cmd("wr100_hit", 4'd1, 16'h0100, 1, 1'b1);
        check_val("wr100_hit.nreq", 32'(aq.size()), 0);
        run_cmd("inv100", 4'd3, 16'h0100, 2, 1'b1);
        check_val("inv100.nreq", 32'(aq.size()), 1);
        check_val("inv100.req0", req_at(0), 32'h0001_0004);
        run_cmd("rd100_after_inv", 4'd0, 16'h0100, 2, 1'b0);
        check_val("rd100_after_inv.req0", req_at(0), 32'h0000_0004);
        check_counts("after_inv", 3, 4, 5, 2, 1);

        run_cmd("noop9", 4'd9, 16'h0100, 1, 1'b0);
        check_val("noop9.nreq", 32'(aq.size()), 0);
        check_counts("after_noop", 3, 4, 5, 2, 1);

        // Fill stalled for 5 cycles: request must hold steady.
        mem_req_ready = 1'b0;
        start_cmd(4'd0, 16'h0300);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (b_mreq_valid && !b_mreq_write && b_add_out == 10'h00C) stable++;
        end
        check_val("stall.stable_cycles", 32'(stable), 5);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        check_val("stall.resp_valid", 32'(b_resp_valid), 1);
        check_val("stall.resp_hit", 32'(b_resp_hit), 0);
        check_counts("after_stall", 3, 5, 6, 2, 2);

        // Clear re-runs INIT, zeroes counters and drops all lines.
        start_cmd(4'd8, 16'h0000);
        check_counts("clear", 0, 0, 0, 0, 0);
        wait_ready(cnt);
        check_val("clear.init_cycles", 32'(cnt), 4);
        run_cmd("rd0_after_clear", 4'd0, 16'h0000, 2, 1'b0);

        // Reset while a fill is pending.
        mem_req_ready = 1'b0;
        start_cmd(4'd0, 16'h0040);
        @(posedge clk); #1;
        check_val("midrst.pre_valid", 32'(b_mreq_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst.mem_req_valid", 32'(b_mreq_valid), 0);
        check_val("midrst.add_out", 32'(b_add_out), 0);
        check_val("midrst.reads", b_reads, 0);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready(cnt);
        check_val("midrst.init_cycles", 32'(cnt), 4);

        // Write-through instance: write hit issues a write request of the line.
        sel = 1'b1;
        run_cmd("wt_wr_miss", 4'd1, 16'h0040, 2, 1'b0);
        check_val("wt_wr_miss.req0", req_at(0), 32'h0000_0001);
        run_cmd("wt_wr_hit", 4'd1, 16'h0040, 2, 1'b1);
        check_val("wt_wr_hit.nreq", 32'(aq.size()), 1);
        check_val("wt_wr_hit.req0", req_at(0), 32'h0001_0001);
        check_counts("wt", 1, 1, 0, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
